// File: rtl/dev_bus_arbiter_pkg.sv
// Shared definitions for the two-master device-bus arbiter: FSM state encoding,
// wait-counter width and the device base addresses decoded by the bridge.
package dev_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int WAIT_W = 4;

  localparam logic [31:0] DEV_TIMER_BASE = 32'h0000_7F00;
  localparam logic [31:0] DEV_OUT_BASE   = 32'h0000_7F10;
  localparam logic [31:0] DEV_IN_BASE    = 32'h0000_7F20;

endpackage

// File: rtl/dev_bus_arbiter_if.sv
// Master-side request/ack signals, registered read data and the bridge pins,
// bundled so the arbiter and its environment share one declaration.
interface dev_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import dev_bus_arbiter_pkg::*;

  // Handshake: a master raises mN_req with we/addr/wd stable and holds it until
  // mN_ack, a single-cycle pulse; req seen during ACCESS or DONE is ignored.
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wd;
  logic              m0_ack;
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wd;
  logic              m1_ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wd;
  logic              bus_wr;
  logic [DATA_W-1:0] bus_rd;
  logic              busy;
  logic              gnt_id;
  state_t            state_dbg;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wd,
    input  m1_req, m1_we, m1_addr, m1_wd,
    input  bus_rd,
    output m0_ack, m1_ack, rdata, bus_addr, bus_wd, bus_wr, busy, gnt_id, state_dbg
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wd,
    output m1_req, m1_we, m1_addr, m1_wd,
    output bus_rd,
    input  m0_ack, m1_ack, rdata, bus_addr, bus_wd, bus_wr, busy, gnt_id, state_dbg
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin pick: a lone requester wins outright; on a tie the
// master that did not win last time is chosen.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       rr_last,
   output logic       win_id,
   output logic       win_valid
);

   always_comb begin
      win_valid = |req;
      win_id    = (req == 2'b11) ? ~rr_last : req[1];
   end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Serialises M0 (CPU) and M1 (DMA/debug) accesses onto the bridge: one granted
// transaction at a time, fixed wait states, a single write strobe, one-cycle ack.
module dev_bus_arbiter
   import dev_bus_arbiter_pkg::*;
#(
   parameter int WAIT_CYC = 1,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32
) (
   input logic              clk,
   input logic              rst_n,
   dev_bus_arbiter_if.slave bus
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYC);

   state_t            state;
   state_t            state_nx;
   logic [WAIT_W-1:0] cnt;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wd;
   logic [DATA_W-1:0] rdata_q;
   logic              gnt_q;
   logic              rr_last;
   logic              win_id;
   logic              win_valid;
   logic              in_access;
   logic              last_access;

   rr_arb2 u_rr_arb2 (
      .req       ({bus.m1_req, bus.m0_req}),
      .rr_last   (rr_last),
      .win_id    (win_id),
      .win_valid (win_valid)
   );

   assign in_access   = (state == ST_ACCESS);
   assign last_access = in_access && (cnt == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (win_valid)   state_nx = ST_ACCESS;
         ST_ACCESS: if (last_access) state_nx = ST_DONE;
         ST_DONE:                    state_nx = ST_IDLE;
         default:                    state_nx = ST_IDLE;
      endcase
   end

   // rr_last starts at 1 so M0 takes the first tie; every grant updates it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         lat_we   <= 1'b0;
         lat_addr <= '0;
         lat_wd   <= '0;
         gnt_q    <= 1'b0;
         rr_last  <= 1'b1;
         rdata_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (win_valid) begin
                  lat_we   <= win_id ? bus.m1_we   : bus.m0_we;
                  lat_addr <= win_id ? bus.m1_addr : bus.m0_addr;
                  lat_wd   <= win_id ? bus.m1_wd   : bus.m0_wd;
                  gnt_q    <= win_id;
                  rr_last  <= win_id;
               end
            end
            ST_ACCESS: begin
               if (last_access) begin
                  if (!lat_we) rdata_q <= bus.bus_rd;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // The bridge sees address 0 (no device) and no strobe outside ACCESS; the
   // write strobe is confined to the first ACCESS cycle.
   always_comb begin
      bus.bus_addr  = in_access ? lat_addr : '0;
      bus.bus_wd    = in_access ? lat_wd   : '0;
      bus.bus_wr    = in_access && (cnt == '0) && lat_we;
      bus.m0_ack    = (state == ST_DONE) && !gnt_q;
      bus.m1_ack    = (state == ST_DONE) &&  gnt_q;
      bus.busy      = (state != ST_IDLE);
      bus.gnt_id    = gnt_q;
      bus.rdata     = rdata_q;
      bus.state_dbg = state;
   end

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Bench for dev_bus_arbiter: directed scenarios plus randomized two-master
// traffic checked against a transaction-level timing model.
module tb_dev_bus_arbiter;
  import dev_bus_arbiter_pkg::*;

  localparam int W = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic rd_fixed_en = 1'b1;
  logic [31:0] rd_fixed = 32'h1234_5678;
  logic [31:0] cyc_v;

  dev_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
  dev_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

  dev_bus_arbiter #(.WAIT_CYC(W), .DATA_W(32), .ADDR_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  dev_bus_arbiter #(.WAIT_CYC(0), .DATA_W(32), .ADDR_W(32)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // device model: read data encodes the current cycle and the presented address
  assign cyc_v = cyc;
  assign a.bus_rd = rd_fixed_en ? rd_fixed : {cyc_v[15:0], a.bus_addr[15:0]};
  assign b.bus_rd = {cyc_v[15:0], b.bus_addr[15:0]};

  // driver tasks
  task automatic idle_inputs();
    a.m0_req = 0; a.m0_we = 0; a.m0_addr = 0; a.m0_wd = 0;
    a.m1_req = 0; a.m1_we = 0; a.m1_addr = 0; a.m1_wd = 0;
    b.m0_req = 0; b.m0_we = 0; b.m0_addr = 0; b.m0_wd = 0;
    b.m1_req = 0; b.m1_we = 0; b.m1_addr = 0; b.m1_wd = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [101:0] act;
    idle_inputs();
    a.m0_req = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    act = {a.m0_ack, a.m1_ack, a.busy, a.bus_wr, a.gnt_id, a.bus_addr, a.bus_wd, a.rdata};
    tests++;
    if (act !== '0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", act); end
    tests++;
    if (a.state_dbg !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", a.state_dbg, ST_IDLE); end
    a.m0_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    int ack_k = -1, addr_n = 0, wr_n = 0, m1_n = 0;
    rd_fixed_en = 1'b1; rd_fixed = 32'h1234_5678;
    a.m0_req = 1; a.m0_we = 0; a.m0_addr = 32'h7F04; a.m0_wd = 32'hDEAD;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (a.bus_addr == 32'h7F04) addr_n++;
      if (a.bus_wr) wr_n++;
      if (a.m1_ack) m1_n++;
      if (a.m0_ack) begin ack_k = k; a.m0_req = 0; end
    end
    tests++; if (addr_n !== 2) begin fails++; $display("FAIL read_addr_cycles: got %0d expected 2", addr_n); end
    tests++; if (wr_n !== 0) begin fails++; $display("FAIL read_no_wr: got %0d expected 0", wr_n); end
    tests++; if (ack_k !== 3) begin fails++; $display("FAIL read_ack_latency: got %0d expected 3", ack_k); end
    tests++; if (m1_n !== 0) begin fails++; $display("FAIL read_wrong_ack: got %0d expected 0", m1_n); end
    tests++; if (a.rdata !== 32'h1234_5678) begin fails++; $display("FAIL read_rdata: got %h expected 12345678", a.rdata); end
    tests++; if (a.gnt_id !== 1'b0) begin fails++; $display("FAIL read_gnt_id: got %0d expected 0", a.gnt_id); end
  endtask

  task automatic test_write();
    int ack_k = -1, wr_n = 0, m0_n = 0;
    logic [31:0] wd_at = '0;
    rd_fixed = 32'h5555_AAAA;
    a.m1_req = 1; a.m1_we = 1; a.m1_addr = 32'h7F14; a.m1_wd = 32'hA5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (a.bus_wr) begin wr_n++; wd_at = a.bus_wd; end
      if (a.m0_ack) m0_n++;
      if (a.m1_ack) begin ack_k = k; a.m1_req = 0; end
    end
    tests++; if (wr_n !== 1) begin fails++; $display("FAIL write_strobe_count: got %0d expected 1", wr_n); end
    tests++; if (wd_at !== 32'hA5) begin fails++; $display("FAIL write_data: got %h expected a5", wd_at); end
    tests++; if (ack_k !== 3) begin fails++; $display("FAIL write_ack_latency: got %0d expected 3", ack_k); end
    tests++; if (m0_n !== 0) begin fails++; $display("FAIL write_wrong_ack: got %0d expected 0", m0_n); end
    tests++; if (a.rdata !== 32'h1234_5678) begin fails++; $display("FAIL write_rdata_held: got %h expected 12345678", a.rdata); end
    tests++; if (a.gnt_id !== 1'b1) begin fails++; $display("FAIL write_gnt_id: got %0d expected 1", a.gnt_id); end
  endtask

  task automatic test_alternate();
    logic exp_q[$];
    logic exp_owner;
    int n_ack = 0, both = 0;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    a.m0_req = 1; a.m0_we = 0; a.m0_addr = 32'h7F00;
    a.m1_req = 1; a.m1_we = 0; a.m1_addr = 32'h7F10;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (a.m0_ack && a.m1_ack) both++;
      if (a.m0_ack || a.m1_ack) begin
        if (exp_q.size() == 0) exp_owner = 1'bx;
        else exp_owner = exp_q.pop_front();
        tests++;
        if (a.m1_ack !== exp_owner) begin fails++; $display("FAIL alt_owner: got %0d expected %0d", a.m1_ack, exp_owner); end
        tests++;
        if (k !== 3 + 4 * n_ack) begin fails++; $display("FAIL alt_spacing: ack at %0d expected %0d", k, 3 + 4 * n_ack); end
        n_ack++;
      end
    end
    a.m0_req = 0; a.m1_req = 0;
    tests++; if (n_ack !== 4) begin fails++; $display("FAIL alt_ack_count: got %0d expected 4", n_ack); end
    tests++; if (both !== 0) begin fails++; $display("FAIL alt_dual_ack: got %0d expected 0", both); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_drop();
    int ack_n = 0, ack_k = -1;
    logic [31:0] addr_k2 = '0, addr_k4 = '1;
    rd_fixed = 32'h0BAD_F00D;
    a.m0_req = 1; a.m0_we = 0; a.m0_addr = 32'h7F08;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) a.m0_addr = 32'h7F0C;
      if (k == 2) begin addr_k2 = a.bus_addr; a.m0_req = 0; end
      if (k == 4) addr_k4 = a.bus_addr;
      if (a.m0_ack) begin ack_n++; ack_k = k; end
    end
    tests++; if (addr_k2 !== 32'h7F08) begin fails++; $display("FAIL drop_latched_addr: got %h expected 7f08", addr_k2); end
    tests++; if (ack_n !== 1 || ack_k !== 3) begin fails++; $display("FAIL drop_ack: got %0d acks at %0d expected 1 at 3", ack_n, ack_k); end
    tests++; if (addr_k4 !== 32'h0) begin fails++; $display("FAIL drop_bus_idle: got %h expected 0", addr_k4); end
    tests++; if (a.rdata !== 32'h0BAD_F00D) begin fails++; $display("FAIL drop_rdata: got %h expected 0badf00d", a.rdata); end
  endtask

  task automatic test_reset_mid();
    logic [101:0] act;
    int bad_n = 0, ack_k = -1;
    a.m1_req = 1; a.m1_we = 1; a.m1_addr = 32'h7F14; a.m1_wd = 32'h77;
    @(negedge clk);
    tests++; if (a.bus_wr !== 1'b1) begin fails++; $display("FAIL abort_wr_seen: got %0d expected 1", a.bus_wr); end
    rst_n = 1'b0; a.m1_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    act = {a.m0_ack, a.m1_ack, a.busy, a.bus_wr, a.gnt_id, a.bus_addr, a.bus_wd, a.rdata};
    tests++; if (act !== '0) begin fails++; $display("FAIL abort_outputs: got %h expected 0", act); end
    tests++; if (a.state_dbg !== ST_IDLE) begin fails++; $display("FAIL abort_state: got %0d expected %0d", a.state_dbg, ST_IDLE); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (a.m0_ack || a.m1_ack || a.bus_wr || a.busy) bad_n++;
    end
    tests++; if (bad_n !== 0) begin fails++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad_n); end
    rd_fixed = 32'hCAFE_F00D;
    a.m1_req = 1; a.m1_we = 0; a.m1_addr = 32'h7F18;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (a.m1_ack) begin ack_k = k; a.m1_req = 0; end
    end
    tests++; if (ack_k !== 3) begin fails++; $display("FAIL post_abort_ack: got %0d expected 3", ack_k); end
    tests++; if (a.rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL post_abort_rdata: got %h expected cafef00d", a.rdata); end
  endtask

  task automatic test_wait0();
    int ack_k = -1, addr_n = 0;
    logic [31:0] acc_cyc, exp_rd;
    acc_cyc = cyc + 1;
    exp_rd = {acc_cyc[15:0], DEV_IN_BASE[15:0]};
    b.m0_req = 1; b.m0_we = 0; b.m0_addr = DEV_IN_BASE;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (b.bus_addr == DEV_IN_BASE) addr_n++;
      if (b.m0_ack) begin ack_k = k; b.m0_req = 0; end
    end
    tests++; if (addr_n !== 1) begin fails++; $display("FAIL w0_access_cycles: got %0d expected 1", addr_n); end
    tests++; if (ack_k !== 2) begin fails++; $display("FAIL w0_ack_latency: got %0d expected 2", ack_k); end
    tests++; if (b.rdata !== exp_rd) begin fails++; $display("FAIL w0_rdata: got %h expected %h", b.rdata, exp_rd); end
  endtask

  // Randomized traffic; the model tracks one outstanding transaction by its
  // grant cycle g and derives every bus output from cycle arithmetic.
  task automatic test_random();
    int idle_from = 0, g = 0, owner = 0, n;
    bit have = 0;
    logic m_last = 1'b1, m_gnt = 1'b0, t_we = 1'b0, win;
    logic [31:0] t_addr = '0, t_wd = '0, m_rdata = '0, x;
    logic req_on[2];
    int gap[2];
    logic we[2];
    logic [31:0] ad[2], wd[2];
    logic [1:0] e_ack;
    logic e_busy, e_wr, ack_i;
    logic [31:0] e_addr, e_wd;
    logic [100:0] exp_v, act_v;
    rd_fixed_en = 1'b0;
    idle_inputs();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      req_on[i] = 0; gap[i] = $urandom_range(0, 3); we[i] = 0; ad[i] = 0; wd[i] = 0;
    end
    repeat (400) begin
      n = cyc;
      e_ack = '0; e_busy = 0; e_wr = 0; e_addr = '0; e_wd = '0;
      if (have) begin
        if (n == g) m_gnt = owner[0];
        if (n >= g && n <= g + W) begin e_addr = t_addr; e_wd = t_wd; end
        if (n == g) e_wr = t_we;
        if (n >= g && n <= g + W + 1) e_busy = 1;
        if (n == g + W + 1) begin
          e_ack[owner] = 1'b1;
          if (!t_we) begin x = g + W; m_rdata = {x[15:0], t_addr[15:0]}; end
        end
      end
      exp_v = {e_ack[1], e_ack[0], e_busy, e_wr, m_gnt, e_addr, e_wd, m_rdata};
      act_v = {a.m1_ack, a.m0_ack, a.busy, a.bus_wr, a.gnt_id, a.bus_addr, a.bus_wd, a.rdata};
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL rand_cycle %0d: got %h expected %h", n, act_v, exp_v);
      end
      for (int i = 0; i < 2; i++) begin
        ack_i = (i == 1) ? a.m1_ack : a.m0_ack;
        if (req_on[i] && ack_i) begin
          req_on[i] = 0; gap[i] = $urandom_range(0, 3);
        end else if (!req_on[i]) begin
          if (gap[i] == 0) begin
            req_on[i] = 1; we[i] = $urandom_range(0, 1);
            ad[i] = 32'h7F00 + $urandom_range(0, 47); wd[i] = $urandom;
          end else gap[i]--;
        end
      end
      if (have && n >= g && n <= g + W && $urandom_range(0, 1) == 1) begin
        ad[owner] = 32'h7F00 + $urandom_range(0, 47); wd[owner] = $urandom;
      end
      a.m0_req = req_on[0]; a.m0_we = we[0]; a.m0_addr = ad[0]; a.m0_wd = wd[0];
      a.m1_req = req_on[1]; a.m1_we = we[1]; a.m1_addr = ad[1]; a.m1_wd = wd[1];
      if (n >= idle_from && (req_on[0] || req_on[1])) begin
        win = (req_on[0] && req_on[1]) ? ~m_last : req_on[1];
        m_last = win; owner = int'(win); have = 1; g = n + 1; idle_from = g + W + 2;
        t_we = we[owner]; t_addr = ad[owner]; t_wd = wd[owner];
      end
      @(negedge clk);
    end
    idle_inputs();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_alternate();
    test_drop();
    test_reset_mid();
    test_wait0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
